// File: rtl/rs_issue_scheduler.sv
// Reservation-station scheduler: tag-based operand wakeup, lowest-index allocate/select,
// one issue per cycle over valid/ack, kill flushes all entries.

module rs_entry #(
    parameter int DATA_LEN = 32,
    parameter int RRF_SEL  = 6
) (
    input  logic                clk,
    input  logic                reset_i,
    input  logic                kill_i,
    input  logic                alloc_en,
    input  logic                free_en,
    input  logic [DATA_LEN-1:0] d_src1,
    input  logic                d_rdy1,
    input  logic [DATA_LEN-1:0] d_src2,
    input  logic                d_rdy2,
    input  logic [RRF_SEL-1:0]  d_rrftag,
    input  logic                wb_valid_i,
    input  logic [RRF_SEL-1:0]  wb_rrftag_i,
    input  logic [DATA_LEN-1:0] wb_data_i,
    output logic                valid,
    output logic [DATA_LEN-1:0] src1,
    output logic                rdy1,
    output logic [DATA_LEN-1:0] src2,
    output logic                rdy2,
    output logic [RRF_SEL-1:0]  rrftag
);
    logic wake1, wake2;

    // An entry leaving this cycle is not woken; its contents are dead anyway.
    assign wake1 = valid && !free_en && !rdy1 && wb_valid_i && (src1[RRF_SEL-1:0] == wb_rrftag_i);
    assign wake2 = valid && !free_en && !rdy2 && wb_valid_i && (src2[RRF_SEL-1:0] == wb_rrftag_i);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            valid  <= 1'b0;
            src1   <= '0;
            rdy1   <= 1'b0;
            src2   <= '0;
            rdy2   <= 1'b0;
            rrftag <= '0;
        end else if (kill_i) begin
            valid <= 1'b0;
        end else if (alloc_en) begin
            valid  <= 1'b1;
            src1   <= d_src1;
            rdy1   <= d_rdy1;
            src2   <= d_src2;
            rdy2   <= d_rdy2;
            rrftag <= d_rrftag;
        end else begin
            if (free_en) valid <= 1'b0;
            if (wake1) begin
                src1 <= wb_data_i;
                rdy1 <= 1'b1;
            end
            if (wake2) begin
                src2 <= wb_data_i;
                rdy2 <= 1'b1;
            end
        end
    end
endmodule

module rs_issue_scheduler #(
    parameter int ENTRY_NUM = 4,
    parameter int DATA_LEN  = 32,
    parameter int RRF_SEL   = 6
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                kill_i,
    input  logic                                dp_valid_i,
    output logic                                dp_ready_o,
    input  logic [DATA_LEN-1:0]                 dp_src1_i,
    input  logic [DATA_LEN-1:0]                 dp_src2_i,
    input  logic                                dp_rdy1_i,
    input  logic                                dp_rdy2_i,
    input  logic [RRF_SEL-1:0]                  dp_rrftag_i,
    input  logic                                wb_valid_i,
    input  logic [RRF_SEL-1:0]                  wb_rrftag_i,
    input  logic [DATA_LEN-1:0]                 wb_data_i,
    output logic                                issue_valid_o,
    input  logic                                issue_ack_i,
    output logic [DATA_LEN-1:0]                 issue_src1_o,
    output logic [DATA_LEN-1:0]                 issue_src2_o,
    output logic [RRF_SEL-1:0]                  issue_rrftag_o,
    output logic [$clog2(ENTRY_NUM):0]          count_o
);
    localparam int IDX_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = IDX_W + 1;

    logic [ENTRY_NUM-1:0]               valid, rdy1, rdy2;
    logic [ENTRY_NUM-1:0][DATA_LEN-1:0] src1, src2;
    logic [ENTRY_NUM-1:0][RRF_SEL-1:0]  rrftag;

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    free_idx, sel_idx;
    logic                sel_found;
    logic                dp_accept, issue_fire;
    logic [DATA_LEN-1:0] byp_src1, byp_src2;
    logic                byp_rdy1, byp_rdy2;

    // Lowest-index free slot and lowest-index ready entry, both from registered state.
    always_comb begin
        cnt       = '0;
        free_idx  = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            cnt = cnt + CNT_W'(valid[i]);
            if (!valid[i]) free_idx = IDX_W'(i);
            if (valid[i] && rdy1[i] && rdy2[i]) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
    end

    assign count_o       = cnt;
    assign dp_ready_o    = (cnt < CNT_W'(ENTRY_NUM));
    assign dp_accept     = dp_valid_i && dp_ready_o;
    assign issue_valid_o = sel_found;
    assign issue_fire    = sel_found && issue_ack_i;

    // Dispatch bypass: catch a broadcast that lands in the same cycle as the write.
    always_comb begin
        byp_rdy1 = dp_rdy1_i;
        byp_src1 = dp_src1_i;
        byp_rdy2 = dp_rdy2_i;
        byp_src2 = dp_src2_i;
        if (!dp_rdy1_i && wb_valid_i && (dp_src1_i[RRF_SEL-1:0] == wb_rrftag_i)) begin
            byp_rdy1 = 1'b1;
            byp_src1 = wb_data_i;
        end
        if (!dp_rdy2_i && wb_valid_i && (dp_src2_i[RRF_SEL-1:0] == wb_rrftag_i)) begin
            byp_rdy2 = 1'b1;
            byp_src2 = wb_data_i;
        end
    end

    always_comb begin
        issue_src1_o   = '0;
        issue_src2_o   = '0;
        issue_rrftag_o = '0;
        if (sel_found) begin
            issue_src1_o   = src1[sel_idx];
            issue_src2_o   = src2[sel_idx];
            issue_rrftag_o = rrftag[sel_idx];
        end
    end

    for (genvar g = 0; g < ENTRY_NUM; g++) begin : g_ent
        rs_entry #(.DATA_LEN(DATA_LEN), .RRF_SEL(RRF_SEL)) u_ent (
            .clk         (clk_i),
            .reset_i     (reset_i),
            .kill_i      (kill_i),
            .alloc_en    (dp_accept && (free_idx == IDX_W'(g))),
            .free_en     (issue_fire && (sel_idx == IDX_W'(g))),
            .d_src1      (byp_src1),
            .d_rdy1      (byp_rdy1),
            .d_src2      (byp_src2),
            .d_rdy2      (byp_rdy2),
            .d_rrftag    (dp_rrftag_i),
            .wb_valid_i  (wb_valid_i),
            .wb_rrftag_i (wb_rrftag_i),
            .wb_data_i   (wb_data_i),
            .valid       (valid[g]),
            .src1        (src1[g]),
            .rdy1        (rdy1[g]),
            .src2        (src2[g]),
            .rdy2        (rdy2[g]),
            .rrftag      (rrftag[g])
        );
    end
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Bench for rs_issue_scheduler: directed vector table, then random traffic vs. a behavioural model.

module tb_rs_issue_scheduler;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst, kill, dpv, r1, r2, wbv, ack;
    logic [31:0] s1, s2, wbd;
    logic [5:0]  tag, wbt;
    logic        dp_ready, iv;
    logic [31:0] is1, is2;
    logic [5:0]  itag;
    logic [2:0]  cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rs_issue_scheduler #(.ENTRY_NUM(N), .DATA_LEN(32), .RRF_SEL(6)) dut (
        .clk_i(clk), .reset_i(rst), .kill_i(kill),
        .dp_valid_i(dpv), .dp_ready_o(dp_ready),
        .dp_src1_i(s1), .dp_src2_i(s2), .dp_rdy1_i(r1), .dp_rdy2_i(r2), .dp_rrftag_i(tag),
        .wb_valid_i(wbv), .wb_rrftag_i(wbt), .wb_data_i(wbd),
        .issue_valid_o(iv), .issue_ack_i(ack),
        .issue_src1_o(is1), .issue_src2_o(is2), .issue_rrftag_o(itag),
        .count_o(cnt)
    );

    typedef struct {
        logic rst, kill, dpv; logic [31:0] s1; logic r1; logic [31:0] s2; logic r2; logic [5:0] tag;
        logic wbv; logic [5:0] wbt; logic [31:0] wbd; logic ack;
        logic eiv; logic [31:0] es1, es2; logic [5:0] etag; logic [2:0] ecnt; logic erdy;
    } vec_t;

    typedef struct { logic v; logic [31:0] s1; logic r1; logic [31:0] s2; logic r2; logic [5:0] tag; } ent_t;
    ent_t me[N];

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic chk_all(input int step, input logic eiv, input logic [31:0] es1, input logic [31:0] es2,
                           input logic [5:0] etag, input logic [2:0] ecnt, input logic erdy);
        chk("issue_valid", step, 32'(iv), 32'(eiv));
        chk("issue_src1", step, is1, es1);
        chk("issue_src2", step, is2, es2);
        chk("issue_rrftag", step, 32'(itag), 32'(etag));
        chk("count", step, 32'(cnt), 32'(ecnt));
        chk("dp_ready", step, 32'(dp_ready), 32'(erdy));
    endtask

    // Model: apply the scheduler's rules to the entry array for one edge using current inputs.
    task automatic model_step();
        ent_t nx[N];
        int   sel, fi, occ;
        sel = -1; fi = -1; occ = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (me[i].v) occ++;
            if (me[i].v && me[i].r1 && me[i].r2) sel = i;
            if (!me[i].v) fi = i;
        end
        nx = me;
        if (rst || kill) begin
            for (int i = 0; i < N; i++) nx[i].v = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (me[i].v && !(ack && i == sel) && wbv) begin
                    if (!me[i].r1 && me[i].s1[5:0] == wbt) begin nx[i].s1 = wbd; nx[i].r1 = 1'b1; end
                    if (!me[i].r2 && me[i].s2[5:0] == wbt) begin nx[i].s2 = wbd; nx[i].r2 = 1'b1; end
                end
            end
            if (ack && sel >= 0) nx[sel].v = 1'b0;
            if (dpv && occ < N) begin
                nx[fi].v = 1'b1; nx[fi].tag = tag;
                nx[fi].s1 = s1; nx[fi].r1 = r1;
                nx[fi].s2 = s2; nx[fi].r2 = r2;
                if (!r1 && wbv && s1[5:0] == wbt) begin nx[fi].s1 = wbd; nx[fi].r1 = 1'b1; end
                if (!r2 && wbv && s2[5:0] == wbt) begin nx[fi].s2 = wbd; nx[fi].r2 = 1'b1; end
            end
        end
        me = nx;
    endtask

    task automatic model_check(input int step);
        int sel, occ;
        sel = -1; occ = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (me[i].v) occ++;
            if (me[i].v && me[i].r1 && me[i].r2) sel = i;
        end
        if (sel >= 0) chk_all(step, 1'b1, me[sel].s1, me[sel].s2, me[sel].tag, 3'(occ), occ < N);
        else          chk_all(step, 1'b0, 32'd0, 32'd0, 6'd0, 3'(occ), occ < N);
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1; kill = 0; dpv = 0; s1 = 0; r1 = 0; s2 = 0; r2 = 0; tag = 0;
        wbv = 0; wbt = 0; wbd = 0; ack = 0;

        //          rst kill dpv s1  r1 s2   r2 tag wbv wbt wbd    ack  eiv es1    es2  etag cnt rdy
        tbl.push_back('{1, 0, 0, 0,  0, 0,   0, 0,  0, 0,  0,     0,   0, 0,     0,   0,  0, 1});
        tbl.push_back('{0, 0, 1, 2,  1, 5,   1, 3,  0, 0,  0,     0,   1, 2,     5,   3,  1, 1});
        tbl.push_back('{0, 0, 0, 0,  0, 0,   0, 0,  0, 0,  0,     1,   0, 0,     0,   0,  0, 1});
        tbl.push_back('{0, 0, 1, 1,  0, 7,   1, 10, 0, 0,  0,     0,   0, 0,     0,   0,  1, 1});
        tbl.push_back('{0, 0, 0, 0,  0, 0,   0, 0,  1, 1,  'h2A,  0,   1, 'h2A,  7,   10, 1, 1});
        tbl.push_back('{0, 0, 0, 0,  0, 0,   0, 0,  0, 0,  0,     1,   0, 0,     0,   0,  0, 1});
        tbl.push_back('{0, 0, 1, 3,  1, 4,   0, 11, 1, 4,  9,     0,   1, 3,     9,   11, 1, 1});
        tbl.push_back('{0, 0, 0, 0,  0, 0,   0, 0,  0, 0,  0,     1,   0, 0,     0,   0,  0, 1});
        for (int e = 0; e < 4; e++)
            tbl.push_back('{0, 0, 1, 20+e, 0, 100+e, 1, 6'(40+e), 0, 0, 0, 0, 0, 0, 0, 0, 3'(e+1), e < 3});
        tbl.push_back('{0, 0, 1, 5,  1, 6,   1, 7,  0, 0,  0,     0,   0, 0,     0,   0,  4, 0});
        tbl.push_back('{0, 0, 0, 0,  0, 0,   0, 0,  1, 22, 'h55,  0,   1, 'h55,  102, 42, 4, 0});
        tbl.push_back('{0, 0, 0, 0,  0, 0,   0, 0,  1, 20, 'h66,  0,   1, 'h66,  100, 40, 4, 0});
        tbl.push_back('{0, 0, 0, 0,  0, 0,   0, 0,  1, 38, 'hFF,  0,   1, 'h66,  100, 40, 4, 0});
        tbl.push_back('{0, 0, 1, 7,  1, 8,   1, 50, 0, 0,  0,     1,   1, 'h55,  102, 42, 3, 1});
        tbl.push_back('{0, 0, 1, 7,  1, 8,   1, 50, 0, 0,  0,     1,   1, 7,     8,   50, 3, 1});
        tbl.push_back('{0, 1, 1, 1,  1, 1,   1, 1,  0, 0,  0,     1,   0, 0,     0,   0,  0, 1});
        tbl.push_back('{0, 0, 1, 1,  1, 2,   1, 1,  0, 0,  0,     0,   1, 1,     2,   1,  1, 1});
        tbl.push_back('{0, 0, 1, 3,  1, 4,   1, 2,  0, 0,  0,     0,   1, 1,     2,   1,  2, 1});
        tbl.push_back('{1, 0, 1, 9,  1, 9,   1, 9,  0, 0,  0,     1,   0, 0,     0,   0,  0, 1});
        tbl.push_back('{0, 0, 0, 0,  0, 0,   0, 0,  0, 0,  0,     0,   0, 0,     0,   0,  0, 1});

        foreach (tbl[k]) begin
            rst = tbl[k].rst; kill = tbl[k].kill; dpv = tbl[k].dpv;
            s1 = tbl[k].s1; r1 = tbl[k].r1; s2 = tbl[k].s2; r2 = tbl[k].r2; tag = tbl[k].tag;
            wbv = tbl[k].wbv; wbt = tbl[k].wbt; wbd = tbl[k].wbd; ack = tbl[k].ack;
            @(posedge clk); #1;
            chk_all(k, tbl[k].eiv, tbl[k].es1, tbl[k].es2, tbl[k].etag, tbl[k].ecnt, tbl[k].erdy);
        end

        // Random traffic; narrow tag range keeps wakeups and bypass hits frequent.
        for (int i = 0; i < N; i++) me[i] = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 6'd0};
        for (int c = 0; c < 3000; c++) begin
            rst  = (c == 0) || ($urandom_range(199) == 0);
            kill = ($urandom_range(39) == 0);
            dpv  = $urandom_range(1);
            r1   = ($urandom_range(2) != 0);
            r2   = ($urandom_range(2) != 0);
            s1   = r1 ? $urandom : (($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(7)));
            s2   = r2 ? $urandom : (($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(7)));
            tag  = 6'($urandom);
            wbv  = $urandom_range(1);
            wbt  = 6'($urandom_range(7));
            wbd  = $urandom;
            ack  = $urandom_range(1);
            model_step();
            @(posedge clk); #1;
            model_check(1000 + c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
